// File: rtl/sa48_ctrl_pkg.sv
// Shared constants, state encoding and slice-carry helper for the 48-bit sequential adder controller.
package sa48_ctrl_pkg;

    localparam int unsigned SLICE_W  = 12;
    localparam int unsigned N_SLICES = 4;
    localparam int unsigned OP_W     = SLICE_W * N_SLICES;
    localparam int unsigned CNT_W    = $clog2(N_SLICES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Carry out of a + b + ci for one slice.
    function automatic logic slice_carry(input logic [SLICE_W-1:0] a,
                                         input logic [SLICE_W-1:0] b,
                                         input logic               ci);
        return ({1'b0, a} + {1'b0, b} + (SLICE_W+1)'(ci)) >= (SLICE_W+1)'(1 << SLICE_W);
    endfunction

endpackage

// File: rtl/sa48_ctrl.sv
// Sequencer feeding 48-bit operands into the 12-bit sequential adder datapath, LSB slice first.
// Optional inter-slice carry chain enabled by defining SA48_CTRL_CARRY_EN.
module sa48_ctrl
    import sa48_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [OP_W-1:0]    op_a,
    input  logic [OP_W-1:0]    op_b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [SLICE_W-1:0] bus_a,
    output logic [SLICE_W-1:0] bus_b,
    output logic               shift_next,
    output logic               carry_out
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [OP_W-1:0]   sa;
    logic [OP_W-1:0]   sb;
    logic              accept;
    logic              last;

    // ready is high exactly in IDLE and DONE, so it doubles as the capture qualifier.
    assign accept = ready && start;
    assign last   = (cnt == CNT_W'(N_SLICES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sa         <= '0;
            sb         <= '0;
            ready      <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            shift_next <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        cnt        <= '0;
                        sa         <= op_a;
                        sb         <= op_b;
                        ready      <= 1'b0;
                        busy       <= 1'b1;
                        shift_next <= 1'b1;
                    end else begin
                        state      <= ST_IDLE;
                        ready      <= 1'b1;
                        busy       <= 1'b0;
                        shift_next <= 1'b0;
                    end
                end
                ST_RUN: begin
                    sa  <= sa >> SLICE_W;
                    sb  <= sb >> SLICE_W;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        state      <= ST_DONE;
                        done       <= 1'b1;
                        ready      <= 1'b1;
                        busy       <= 1'b0;
                        shift_next <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    ready      <= 1'b1;
                    busy       <= 1'b0;
                    shift_next <= 1'b0;
                end
            endcase
        end
    end

    // Buses are zero outside RUN so the datapath only ever sees live slices.
    assign bus_b = busy ? sb[SLICE_W-1:0] : '0;

`ifdef SA48_CTRL_CARRY_EN
    logic c;

    always_ff @(posedge clk) begin
        if (rst) begin
            c         <= 1'b0;
            carry_out <= 1'b0;
        end else if (accept) begin
            c         <= 1'b0;
            carry_out <= 1'b0;
        end else if (busy) begin
            c <= slice_carry(sa[SLICE_W-1:0], sb[SLICE_W-1:0], c);
            if (last) begin
                carry_out <= slice_carry(sa[SLICE_W-1:0], sb[SLICE_W-1:0], c);
            end
        end
    end

    // Folding the carry into A keeps the datapath a plain per-slice adder.
    assign bus_a = busy ? (sa[SLICE_W-1:0] + SLICE_W'(c)) : '0;
`else
    assign bus_a     = busy ? sa[SLICE_W-1:0] : '0;
    assign carry_out = 1'b0;
`endif

endmodule
